axis_packet_arbiter: RTL and testbench

- Shares one 1024-bit AXI-Stream output between NUM_SRC packet sources, each shaped like the rand_to_axi output (1024-bit data, 128-bit byte keep, valid/last).
- Arbitrates round-robin at packet granularity: a grant is held from the first beat to the beat carrying last.
- Drives a single registered output stage and counts forwarded packets per source.
- Sits between several shifter/packer pipelines and the host-facing stream port.

---
 rtl/axis_packet_arbiter.sv | 78 +++++++
 tb/tb_axis_packet_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: round-robin packet-granular arbiter of NUM_SRC AXI-Stream sources onto one registered output
module axis_packet_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W = 1024,
  parameter int KEEP_W = 128,
  parameter int SRC_W = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  in_data,
  input  logic [NUM_SRC-1:0][KEEP_W-1:0]  in_keep,
  input  logic [NUM_SRC-1:0]              in_valid,
  input  logic [NUM_SRC-1:0]              in_last,
  output logic [NUM_SRC-1:0]              in_ready,
  input  logic                            ready_4_output,
  output logic [DATA_W-1:0]               out_data,
  output logic [KEEP_W-1:0]               out_keep,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [SRC_W-1:0]                out_src,
  output logic                            busy,
  output logic [NUM_SRC-1:0][31:0]        pkt_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [SRC_W-1:0] g, g_n, rr_ptr, pick, idx, g_inc;
  logic slot_free, accept, done;
  assign slot_free = !out_valid || ready_4_output;
  assign busy = state == BUSY;
  assign accept = busy && in_valid[g] && slot_free;
  assign done = accept && in_last[g];
  assign in_ready = busy && slot_free ? NUM_SRC'(1) << g : '0;
  assign g_inc = g == SRC_W'(NUM_SRC - 1) ? '0 : g + SRC_W'(1);
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      pick = in_valid[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (|in_valid ? BUSY : IDLE) : (done ? IDLE : BUSY);
    g_n = state == IDLE && |in_valid ? pick : g;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_keep <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_src <= '0;
      pkt_count <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept) begin
        out_data <= in_data[g];
        out_keep <= in_keep[g];
        out_last <= in_last[g];
        out_src <= g;
      end
      out_valid <= accept || (out_valid && !ready_4_output);
      if (done) begin
        pkt_count[g] <= pkt_count[g] + 32'd1;
        rr_ptr <= g_inc;
      end
    end
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: scoreboard and table-driven bench for axis_packet_arbiter
module tb_axis_packet_arbiter;
  localparam int N = 4;
  localparam int DW = 1024;
  localparam int KW = 128;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0][DW-1:0] in_data = '0;
  logic [N-1:0][KW-1:0] in_keep = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [N-1:0] in_ready;
  logic ready_4_output = 1;
  logic [DW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic out_valid, out_last, busy;
  logic [1:0] out_src;
  logic [N-1:0][31:0] pkt_count;
  typedef struct {logic [DW-1:0] d; logic [KW-1:0] k; logic l; logic [1:0] s;} beat_t;
  typedef struct {int src; int beats; logic [KW-1:0] keep; int exp_cnt;} vec_t;
  beat_t sb[$];
  int grant_log[$];
  int errors = 0, checks = 0, cyc = 0, nout = 0, first_out = -1, last_out = -1;
  logic [N-1:0] mid = '0;
  logic chk_stall = 0, held_v = 0;
  logic [DW-1:0] held;
  localparam logic [KW-1:0] ONES = {KW{1'b1}};
  localparam logic [KW-1:0] A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_SRC(N), .DATA_W(DW), .KEEP_W(KW), .SRC_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .ready_4_output(ready_4_output),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
    .out_src(out_src), .busy(busy), .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      mid = '0;
      held_v = 0;
    end else begin
      if (out_valid && ready_4_output) begin
        checks++;
        nout++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: output beat src=%0d with no expected beat", out_src);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_keep, out_last, out_src} !== {e.d, e.k, e.l, e.s}) begin
            errors++;
            $display("FAIL beat: got src=%0d last=%0b keep=%h data=%h expected src=%0d last=%0b keep=%h data=%h",
                     out_src, out_last, out_keep, out_data[63:0], e.s, e.l, e.k, e.d[63:0]);
          end
        end
      end
      for (int s = 0; s < N; s++)
        if (in_valid[s] && in_ready[s]) begin
          sb.push_back('{d: in_data[s], k: in_keep[s], l: in_last[s], s: 2'(s)});
          if (!mid[s]) grant_log.push_back(s);
          mid[s] = !in_last[s];
        end
      if (chk_stall && out_valid && !ready_4_output) begin
        chk("stall_in_ready", 64'(in_ready), 0);
        if (held_v) chk("stall_hold", 64'(out_data == held), 1);
        held = out_data;
        held_v = 1;
      end else held_v = 0;
    end
  end

  task automatic wait_acc(input int s);
    int t = 0;
    @(negedge clk);
    while (!in_ready[s] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: src %0d never accepted", s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int s, input int n, input logic [KW-1:0] k, input int gap_at);
    for (int b = 0; b < n; b++) begin
      in_data[s] = rnd();
      in_keep[s] = k;
      in_last[s] = b == n - 1;
      in_valid[s] = 1;
      wait_acc(s);
      if (b == gap_at) begin
        in_valid[s] = 0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    in_valid[s] = 0;
    in_last[s] = 0;
  endtask

  task automatic pulse_rst();
    in_valid = '0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic lock_test(input bit with2);
    pulse_rst();
    grant_log.delete();
    fork
      send_pkt(1, 3, ONES, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        in_valid[0] = 1;
        in_last[0] = 1;
        @(negedge clk);
        chk("lock_ready0", 64'(in_ready[0]), 0);
        chk("lock_busy", 64'(busy), 1);
        send_pkt(0, 1, ONES, -1);
      end
      begin
        if (with2) begin
          repeat (2) @(posedge clk);
          #1;
          send_pkt(2, 1, ONES, -1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("lock_ngrant", grant_log.size(), with2 ? 3 : 2);
    if (grant_log.size() >= 2) begin
      chk("lock_g0", grant_log[0], 1);
      chk("lock_g1", grant_log[1], with2 ? 2 : 0);
      if (with2 && grant_log.size() >= 3) chk("lock_g2", grant_log[2], 0);
    end
  endtask

  initial begin
    vec_t vt[6];
    logic [3:0] pat = 4'b1001;
    logic [N-1:0][31:0] snap;
    int n0;
    vt[0] = '{src: 1, beats: 1, keep: ONES, exp_cnt: 1};
    vt[1] = '{src: 2, beats: 2, keep: A5, exp_cnt: 1};
    vt[2] = '{src: 0, beats: 1, keep: '0, exp_cnt: 2};
    vt[3] = '{src: 3, beats: 4, keep: {64{2'b10}}, exp_cnt: 1};
    vt[4] = '{src: 1, beats: 3, keep: ONES, exp_cnt: 2};
    vt[5] = '{src: 0, beats: 2, keep: A5, exp_cnt: 3};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_last", 64'(out_last), 0);
    chk("rst_data", 64'(|out_data), 0);
    chk("rst_keep", 64'(|out_keep), 0);
    chk("rst_src", 64'(out_src), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_count", 64'(|pkt_count), 0);
    @(posedge clk);
    #1;
    rst = 0;
    send_pkt(0, 3, ONES, -1);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_count", pkt_count[0], 1);
    chk("t1_last", 64'(out_last), 1);
    chk("t1_src", 64'(out_src), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_nout", nout, 3);
    for (int i = 0; i < 6; i++) begin
      send_pkt(vt[i].src, vt[i].beats, vt[i].keep, -1);
      chk("tbl_busy", 64'(busy), 0);
      chk("tbl_count", pkt_count[vt[i].src], vt[i].exp_cnt);
      chk("tbl_src", 64'(out_src), vt[i].src);
    end
    repeat (2) @(posedge clk);
    #1;
    pulse_rst();
    grant_log.delete();
    first_out = -1;
    fork
      begin send_pkt(0, 2, ONES, -1); send_pkt(0, 2, ONES, -1); end
      begin send_pkt(1, 2, ONES, -1); send_pkt(1, 2, ONES, -1); end
      begin send_pkt(2, 2, ONES, -1); send_pkt(2, 2, ONES, -1); end
      begin send_pkt(3, 2, ONES, -1); send_pkt(3, 2, ONES, -1); end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rr_ngrant", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_grant", grant_log[i], i % 4);
    chk("rr_span", last_out - first_out, 22);
    n0 = nout;
    chk_stall = 1;
    fork
      send_pkt(2, 4, A5, -1);
      begin
        for (int k = 0; k < 24; k++) begin
          ready_4_output = pat[k % 4];
          @(posedge clk);
          #1;
        end
        ready_4_output = 1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk_stall = 0;
    chk("bp_nout", nout - n0, 4);
    lock_test(0);
    lock_test(1);
    grant_log.delete();
    in_data[1] = rnd();
    in_keep[1] = ONES;
    in_last[1] = 0;
    in_valid[1] = 1;
    wait_acc(1);
    in_data[1] = rnd();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    in_valid[1] = 0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_count", 64'(|pkt_count), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      send_pkt(0, 1, ONES, -1);
      send_pkt(1, 1, ONES, -1);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_ngrant", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("mid_rst_g0", grant_log[0], 0);
      chk("mid_rst_g1", grant_log[1], 1);
    end
    snap = pkt_count;
    snap[3] = 32'hFFFF_FFFF;
    force dut.pkt_count = snap;
    #1;
    release dut.pkt_count;
    send_pkt(3, 1, '0, -1);
    chk("wrap_valid", 64'(out_valid), 1);
    chk("wrap_keep", 64'(|out_keep), 0);
    chk("wrap_last", 64'(out_last), 1);
    chk("wrap_src", 64'(out_src), 3);
    chk("wrap_count3", pkt_count[3], 0);
    chk("wrap_count0", pkt_count[0], snap[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
